// File: rtl/gpr_cdb_arbiter_pkg.sv
// Shared types and constants for the GPR common data bus arbiter.
package gpr_cdb_arbiter_pkg;

    // Width of a reorder-buffer tag.
    localparam int unsigned ROB_WIDTH = 6;

    // Number of integer-side units competing for the GPR CDB.
    localparam int unsigned N_GPR_CDB_REQ = 4;

    // One broadcast on the common data bus.
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

endpackage

// File: rtl/gpr_cdb_arbiter_rr_pick.sv
// rr_pick: combinational wrap-around priority encoder.
// Scans valid[ptr], valid[ptr+1], ..., valid[N-1], valid[0], ... and returns
// the first set index. With ptr tied to 0 it is a plain lowest-index encoder.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid,
    input  logic [PtrW-1:0] ptr,
    output logic            found,
    output logic [PtrW-1:0] idx
);

    int unsigned     pos;
    logic [PtrW-1:0] pos_idx;

    // Walk offsets from ptr upward; the first valid slot wins.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = PtrW'(pos);
            if (!found && valid[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// gpr_cdb_arbiter: grants the GPR common data bus to one requesting unit per
// cycle and broadcasts the winner's tag and result one cycle later.
// Define CDB_RR_EN for round-robin priority; otherwise lowest index wins and
// no pointer state exists.
module gpr_cdb_arbiter
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_GPR_CDB_REQ
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*ROB_WIDTH-1:0] req_tag,
    input  logic [N_REQ*32-1:0]        req_result,
    input  logic                       cdb_hold,
    output cdb_t                       gpr_cdb
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                 pick_found;
    logic [PtrW-1:0]      pick_idx;
    logic [PtrW-1:0]      pick_ptr;
    logic                 grant;

    logic                 win_q, win_d;
    logic [PtrW-1:0]      idx_q, idx_d;
    logic [ROB_WIDTH-1:0] tag_q, tag_d;

`ifdef CDB_RR_EN
    logic [PtrW-1:0]      ptr_q, ptr_d;

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    rr_pick #(
        .N    (N_REQ),
        .PtrW (PtrW)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Hold and reset block new grants only; registered broadcasts still go out.
    assign grant = pick_found && !cdb_hold && !reset;

    // One-hot grant to the winner.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // Capture the winner and its tag; idx/tag only matter while win is set.
    always_comb begin
        win_d = grant;
        idx_d = idx_q;
        tag_d = tag_q;
        if (grant) begin
            idx_d = pick_idx;
            tag_d = req_tag[pick_idx*ROB_WIDTH +: ROB_WIDTH];
        end
    end

`ifdef CDB_RR_EN
    // Advance the pointer past the winner; idle or held cycles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            if (pick_idx == PtrW'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + PtrW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Winner registers feeding next cycle's broadcast.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= 1'b0;
            idx_q <= '0;
            tag_q <= '0;
        end else begin
            win_q <= win_d;
            idx_q <= idx_d;
            tag_q <= tag_d;
        end
    end

    // Broadcast: data is muxed live from the winner's held result.
    always_comb begin
        gpr_cdb.valid = win_q;
        gpr_cdb.tag   = tag_q;
        gpr_cdb.data  = req_result[idx_q*32 +: 32];
    end

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Directed bench for gpr_cdb_arbiter. Inputs change 1 time unit after posedge;
// outputs are sampled on the negedge.
module tb_gpr_cdb_arbiter;
    import gpr_cdb_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned TW = ROB_WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*TW-1:0]  req_tag;
    logic [NR*32-1:0]  req_result;
    logic              cdb_hold;
    cdb_t              gpr_cdb;

    int checks = 0;
    int errors = 0;

    gpr_cdb_arbiter #(
        .N_REQ (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_result (req_result),
        .cdb_hold   (cdb_hold),
        .gpr_cdb    (gpr_cdb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        cdb_hold  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 4'b1111;
        cdb_hold   = 1'b0;
        req_tag    = '0;
        req_result = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready c=%0d got %b exp 0000", c, req_ready);
            end
            step();
        end
        reset     = 1'b0;
        req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || gpr_cdb.valid !== 1'b0) begin
                errors++;
                $display("FAIL idle c=%0d got ready=%b valid=%b exp 0000/0",
                         c, req_ready, gpr_cdb.valid);
            end
            step();
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid             = 4'b0100;
        req_tag[2*TW +: TW]   = TW'(5);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got %b exp 0100", req_ready);
        end
        step();
        req_valid               = 4'b0000;
        req_result[2*32 +: 32]  = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(5) ||
            gpr_cdb.data !== 32'hDEADBEEF || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_bcast got v=%b t=%0d d=%h r=%b exp 1/5/deadbeef/0000",
                     gpr_cdb.valid, gpr_cdb.tag, gpr_cdb.data, req_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (gpr_cdb.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after got v=%b exp 0", gpr_cdb.valid);
        end
        step();
    endtask

    task automatic test_priority();
        logic [NR-1:0] exp_r;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_tag[i*TW +: TW]    = TW'(i + 1);
            req_result[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        end
`ifdef CDB_RR_EN
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_r = NR'(1 << (c % 4));
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, exp_r);
            end
            if (c > 0) begin
                checks++;
                if (gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(((c - 1) % 4) + 1) ||
                    gpr_cdb.data !== 32'hA000_0000 + 32'((c - 1) % 4)) begin
                    errors++;
                    $display("FAIL rr_bcast c=%0d got v=%b t=%0d d=%h exp tag %0d",
                             c, gpr_cdb.valid, gpr_cdb.tag, gpr_cdb.data,
                             ((c - 1) % 4) + 1);
                end
            end
            step();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(4)) begin
            errors++;
            $display("FAIL rr_last got v=%b t=%0d exp 1/4", gpr_cdb.valid, gpr_cdb.tag);
        end
        step();
`else
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0010) begin
                errors++;
                $display("FAIL fixed_grant c=%0d got %b exp 0010", c, req_ready);
            end
            if (c > 0) begin
                checks++;
                if (gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(2) ||
                    gpr_cdb.data !== 32'hA000_0001) begin
                    errors++;
                    $display("FAIL fixed_bcast c=%0d got v=%b t=%0d d=%h exp 1/2/a0000001",
                             c, gpr_cdb.valid, gpr_cdb.tag, gpr_cdb.data);
                end
            end
            step();
        end
        req_valid = 4'b0000;
        step();
`endif
    endtask

    task automatic test_hold();
        logic [NR-1:0] exp_r;
        do_reset();
        req_valid = 4'b0100;
        cdb_hold  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || (c > 0 && gpr_cdb.valid !== 1'b0)) begin
                errors++;
                $display("FAIL hold c=%0d got ready=%b v=%b exp 0000/0",
                         c, req_ready, gpr_cdb.valid);
            end
            step();
        end
        cdb_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || gpr_cdb.valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got ready=%b v=%b exp 0100/0",
                     req_ready, gpr_cdb.valid);
        end
        step();
        req_valid = 4'b1111;
        @(negedge clk);
`ifdef CDB_RR_EN
        exp_r = 4'b1000;
`else
        exp_r = 4'b0001;
`endif
        checks++;
        if (req_ready !== exp_r || gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(3)) begin
            errors++;
            $display("FAIL hold_after got ready=%b v=%b t=%0d exp %b/1/3",
                     req_ready, gpr_cdb.valid, gpr_cdb.tag, exp_r);
        end
        step();
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            req_tag[1*TW +: TW]    = TW'(10 + c);
            req_result[1*32 +: 32] = 32'h1111_0000 + 32'(c);
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0010) begin
                errors++;
                $display("FAIL b2b_grant c=%0d got %b exp 0010", c, req_ready);
            end
            if (c > 0) begin
                checks++;
                if (gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(9 + c) ||
                    gpr_cdb.data !== 32'h1111_0000 + 32'(c)) begin
                    errors++;
                    $display("FAIL b2b_bcast c=%0d got v=%b t=%0d d=%h exp 1/%0d/%h",
                             c, gpr_cdb.valid, gpr_cdb.tag, gpr_cdb.data, 9 + c,
                             32'h1111_0000 + 32'(c));
                end
            end
            step();
        end
        // Alternate units 0 and 3 with no bubble between broadcasts.
        req_tag[0*TW +: TW] = TW'(20);
        req_tag[3*TW +: TW] = TW'(23);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL alt_grant0 got %b exp 0001", req_ready);
        end
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000 || gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(20)) begin
            errors++;
            $display("FAIL alt_grant3 got ready=%b v=%b t=%0d exp 1000/1/20",
                     req_ready, gpr_cdb.valid, gpr_cdb.tag);
        end
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(23)) begin
            errors++;
            $display("FAIL alt_bcast3 got v=%b t=%0d exp 1/23", gpr_cdb.valid, gpr_cdb.tag);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid           = 4'b0010;
        req_tag[1*TW +: TW] = TW'(7);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_grant got %b exp 0010", req_ready);
        end
        step();
        reset                  = 1'b1;
        req_valid              = 4'b1111;
        req_result[1*32 +: 32] = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || gpr_cdb.valid !== 1'b1 || gpr_cdb.tag !== TW'(7) ||
            gpr_cdb.data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rmid_bcast got r=%b v=%b t=%0d d=%h exp 0000/1/7/cafef00d",
                     req_ready, gpr_cdb.valid, gpr_cdb.tag, gpr_cdb.data);
        end
        step();
        reset     = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (gpr_cdb.valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_cleared got v=%b exp 0", gpr_cdb.valid);
        end
        step();
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_ptr0 got %b exp 0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
